// File: rtl/a2d_seq.sv
// A2D conversion sequencer: paces conversions from a programmable period, walks
// a masked channel set round-robin, captures results and flags stalled conversions.
`timescale 1ns/1ps
module a2d_seq #(
  parameter int  NUM_CH = 3,
  parameter int  DATA_W = 12,
  parameter int  PER_W  = 19,
  parameter int  TMO    = 1024,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [PER_W-1:0]         period,
  output logic                     strt_cnv,
  output logic [CH_W-1:0]          chnnl,
  input  logic                     cnv_cmplt,
  input  logic [DATA_W-1:0]        res,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_vld,
  output logic                     nxt,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int              TMO_W    = $clog2(TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  typedef enum logic [1:0] {IDLE, START, CONV} state_t;

  state_t           state, state_nxt;
  logic [PER_W-1:0] per_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CH_W-1:0]  last;
  logic [CH_W-1:0]  pick;
  logic             tick, launch, done, expired, leaving;

  // Smallest enabled index above 'after', wrapping to the smallest enabled index.
  function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W-1:0]   after);
    logic [CH_W-1:0] lowest, above;
    logic            has_above;
    lowest    = '0;
    above     = '0;
    has_above = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = CH_W'(i);
        if (i > int'(after)) begin
          above     = CH_W'(i);
          has_above = 1'b1;
        end
      end
    end
    return has_above ? above : lowest;
  endfunction

  function automatic logic [CH_W-1:0] top_ch(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] top;
    top = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) top = CH_W'(i);
    end
    return top;
  endfunction

  assign tick    = en && (per_cnt == period);
  assign launch  = (state == IDLE) && tick && (|ch_mask);
  assign pick    = next_ch(ch_mask, last);
  assign done    = (state == CONV) && cnv_cmplt;
  assign expired = (state == CONV) && !cnv_cmplt && (tmo_cnt == TMO_LAST);
  assign leaving = done || expired;

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)              per_cnt <= '0;
    else if (!en || tick) per_cnt <= '0;
    else                  per_cnt <= per_cnt + PER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the comb block assigns a default first so no path leaves state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = START;
      START:   state_nxt = CONV;
      CONV:    if (leaving) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strt_cnv = (state == START);
    busy     = (state != IDLE);
  end

  // NOTE: the result slots are ordinary flops, not a RAM, so they take the
  // reset and read back as zero until first written.
  always_ff @(posedge clk) begin
    if (rst) begin
      chnnl       <= '0;
      last        <= CH_W'(NUM_CH - 1);
      tmo_cnt     <= '0;
      ch_data     <= '0;
      ch_vld      <= '0;
      nxt         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (launch) chnnl <= pick;

      if (state == START)     tmo_cnt <= '0;
      else if (state == CONV) tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (done) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (CH_W'(i) == chnnl) begin
            ch_data[i*DATA_W +: DATA_W] <= res;
            ch_vld[i]                   <= 1'b1;
          end
        end
      end

      if (leaving) last <= chnnl;
      if (expired) timeout_err <= 1'b1;

      // End of sweep is judged against the mask as it stands when CONV is left.
      nxt <= leaving && (|ch_mask) && (chnnl == top_ch(ch_mask));
    end
  end

endmodule

// File: tb/tb_a2d_seq.sv
// Self-checking bench for a2d_seq: stimulus table, randomized sweeps against a
// transaction-level model, and hand-written timeout / reset corner cases.
`timescale 1ns/1ps
module tb_a2d_seq;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 12;
  localparam int PER_W  = 19;
  localparam int TMO    = 1024;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst, en, cnv_cmplt;
  logic [NUM_CH-1:0]        ch_mask;
  logic [PER_W-1:0]         period;
  logic [DATA_W-1:0]        res;
  logic                     strt_cnv, nxt, busy, timeout_err;
  logic [CH_W-1:0]          chnnl;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_vld;

  a2d_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PER_W(PER_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .period(period),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res),
    .ch_data(ch_data), .ch_vld(ch_vld), .nxt(nxt), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]      mask;
    logic [7:0]      per;
    logic [7:0]      lat;
    logic [7:0]      space;
    logic [0:3][1:0] seq;
    logic [2:0]      vld;
    logic [3:0]      n_nxt;
  } vec_t;

  int n_checks = 0, n_err = 0;
  int cyc = 0, en_cyc = 0;
  int lat_r = -1, pend_cyc = -1, pend_ch = 0;
  int busy_until = -1, busy_bad = 0, err_cyc = -1;
  bit rnd_r = 1'b0;
  int st_cyc[$], st_ch[$], nxt_cyc[$], exp_seq_q[$];
  logic [DATA_W-1:0] exp_data [NUM_CH];
  logic [NUM_CH-1:0] exp_vld;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int fst(input int k);
    return (k < st_cyc.size()) ? st_cyc[k] : -100000;
  endfunction

  function automatic int fch(input int k);
    return (k < st_ch.size()) ? st_ch[k] : -1;
  endfunction

  function automatic int hi_idx(input logic [NUM_CH-1:0] m);
    int h = -1;
    for (int i = 0; i < NUM_CH; i++) if (m[i]) h = i;
    return h;
  endfunction

  function automatic int rr_next(input int last, input logic [NUM_CH-1:0] m);
    for (int k = 1; k <= NUM_CH; k++) if (m[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  // One clock: observe outputs at the falling edge, then drive the A2D side.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cnv_cmplt) begin
      exp_data[pend_ch] = res;
      exp_vld[pend_ch]  = 1'b1;
    end
    if (strt_cnv) begin
      st_cyc.push_back(cyc);
      st_ch.push_back(int'(chnnl));
      busy_until = cyc + ((lat_r >= 0 && lat_r <= TMO) ? lat_r : TMO);
      if (lat_r >= 0) begin
        pend_cyc = cyc + lat_r;
        pend_ch  = int'(chnnl);
      end
    end
    if (nxt) nxt_cyc.push_back(cyc);
    if (timeout_err && err_cyc < 0) err_cyc = cyc;
    if (busy !== (cyc <= busy_until)) busy_bad++;
    cnv_cmplt = (cyc == pend_cyc);
    if (cnv_cmplt) res = rnd_r ? DATA_W'($urandom) : DATA_W'(12'h100 + pend_ch);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    en  = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_ch.delete(); nxt_cyc.delete();
    pend_cyc = -1; busy_until = -1; busy_bad = 0; err_cyc = -1;
    cnv_cmplt = 1'b0; exp_vld = '0;
    for (int i = 0; i < NUM_CH; i++) exp_data[i] = '0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int g = 0;
    while (st_cyc.size() < n && g < budget) begin step(); g++; end
    if (st_cyc.size() < n) check("start_wait", st_cyc.size(), n);
  endtask

  task automatic run_until(input int target, input int budget);
    int g = 0;
    while (cyc < target && g < budget) begin step(); g++; end
  endtask

  task automatic run_scn(input logic [2:0] mask, input int per, input int lat,
                         input int nst, input bit rnd);
    do_reset(2);
    clear_logs();
    rnd_r   = rnd;
    lat_r   = lat;
    ch_mask = mask;
    period  = PER_W'(per);
    en      = 1'b1;
    en_cyc  = cyc;
    wait_starts(nst, 4000);
    repeat (lat + 3) step();
  endtask

  task automatic check_run(input string tag, input logic [2:0] mask, input int per,
                           input int lat, input int space, input int nst, input int n_nxt);
    int hi, found;
    hi = hi_idx(mask);
    check({tag, " first_start"}, fst(0), en_cyc + per + 1);
    for (int k = 0; k < nst; k++)
      check($sformatf("%s chnnl[%0d]", tag, k), fch(k), exp_seq_q[k]);
    for (int k = 1; k < nst; k++)
      check($sformatf("%s spacing[%0d]", tag, k), fst(k) - fst(k - 1), space);
    check({tag, " ch_vld"}, ch_vld, exp_vld);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("%s ch_data[%0d]", tag, i), ch_data[i*DATA_W +: DATA_W], exp_data[i]);
    check({tag, " nxt_count"}, nxt_cyc.size(), n_nxt);
    foreach (nxt_cyc[j]) begin
      found = 0;
      foreach (st_cyc[k]) if (st_ch[k] == hi && st_cyc[k] + lat + 1 == nxt_cyc[j]) found = 1;
      check($sformatf("%s nxt_timing[%0d]", tag, j), found, 1);
    end
    check({tag, " busy_profile"}, busy_bad, 0);
  endtask

  vec_t vecs [5];

  initial begin
    int s0, last, hi, n_nxt, st0m;
    logic [2:0] m;
    int per, lat, space;

    vecs[0] = '{mask:3'b111, per:8'd9, lat:8'd4, space:8'd10, seq:{2'd0,2'd1,2'd2,2'd0}, vld:3'b111, n_nxt:4'd1};
    vecs[1] = '{mask:3'b101, per:8'd4, lat:8'd1, space:8'd5,  seq:{2'd0,2'd2,2'd0,2'd2}, vld:3'b101, n_nxt:4'd2};
    vecs[2] = '{mask:3'b010, per:8'd2, lat:8'd1, space:8'd3,  seq:{2'd1,2'd1,2'd1,2'd1}, vld:3'b010, n_nxt:4'd4};
    vecs[3] = '{mask:3'b111, per:8'd0, lat:8'd6, space:8'd8,  seq:{2'd0,2'd1,2'd2,2'd0}, vld:3'b111, n_nxt:4'd1};
    vecs[4] = '{mask:3'b110, per:8'd3, lat:8'd2, space:8'd4,  seq:{2'd1,2'd2,2'd1,2'd2}, vld:3'b110, n_nxt:4'd2};

    rst = 1'b1; en = 1'b0; ch_mask = 3'b111; period = '0; cnv_cmplt = 1'b0; res = '0;

    // Reset then a long disabled stretch: nothing may move.
    do_reset(2);
    clear_logs();
    repeat (50) step();
    check("idle starts", st_cyc.size(), 0);
    check("idle strt_cnv", strt_cnv, 1'b0);
    check("idle busy", busy, 1'b0);
    check("idle chnnl", chnnl, '0);
    check("idle ch_data", ch_data, '0);
    check("idle ch_vld", ch_vld, '0);
    check("idle nxt", nxt, 1'b0);
    check("idle timeout_err", timeout_err, 1'b0);

    // Empty mask: ticks every cycle but no conversion starts.
    ch_mask = '0; period = '0; en = 1'b1;
    repeat (30) step();
    check("mask0 starts", st_cyc.size(), 0);
    check("mask0 busy", busy, 1'b0);

    // Table-driven sweeps.
    for (int r = 0; r < 5; r++) begin
      run_scn(vecs[r].mask, int'(vecs[r].per), int'(vecs[r].lat), 4, 1'b0);
      exp_seq_q.delete();
      for (int k = 0; k < 4; k++) exp_seq_q.push_back(int'(vecs[r].seq[k]));
      exp_vld = vecs[r].vld;
      for (int i = 0; i < NUM_CH; i++)
        exp_data[i] = vecs[r].vld[i] ? DATA_W'(12'h100 + i) : '0;
      check_run($sformatf("vec%0d", r), vecs[r].mask, int'(vecs[r].per), int'(vecs[r].lat),
                int'(vecs[r].space), 4, int'(vecs[r].n_nxt));
    end

    // Randomized sweeps against the transaction-level model.
    for (int it = 0; it < 8; it++) begin
      m     = 3'($urandom_range(1, 7));
      per   = $urandom_range(0, 12);
      lat   = $urandom_range(1, 10);
      space = ((lat + 2 + per) / (per + 1)) * (per + 1);
      run_scn(m, per, lat, 6, 1'b1);
      exp_seq_q.delete();
      last = NUM_CH - 1;
      for (int k = 0; k < 16; k++) begin
        last = rr_next(last, m);
        exp_seq_q.push_back(last);
      end
      hi    = hi_idx(m);
      st0m  = en_cyc + per + 1;
      n_nxt = 0;
      for (int k = 0; k < 16; k++)
        if (exp_seq_q[k] == hi && st0m + k * space + lat + 1 <= cyc) n_nxt++;
      check_run($sformatf("rnd%0d", it), m, per, lat, space, 6, n_nxt);
    end

    // A2D never answers: timeout exactly TMO cycles after entering CONV.
    do_reset(2); clear_logs();
    rnd_r = 1'b0; lat_r = -1; ch_mask = 3'b011; period = PER_W'(1049); en = 1'b1;
    wait_starts(1, 1200);
    run_until(fst(0) + TMO + 1, 1200);
    check("tmo rise", err_cyc - (fst(0) + 1), TMO);
    check("tmo first chnnl", fch(0), 0);
    check("tmo busy", busy, 1'b0);
    check("tmo ch_vld", ch_vld, '0);
    check("tmo ch_data", ch_data, '0);
    check("tmo no nxt", nxt_cyc.size(), 0);
    wait_starts(2, 1200);
    check("tmo next chnnl", fch(1), 1);
    check("tmo sticky", timeout_err, 1'b1);
    run_until(fst(1) + TMO + 2, 1200);
    check("tmo nxt count", nxt_cyc.size(), 1);
    check("tmo nxt cycle", (nxt_cyc.size() > 0) ? nxt_cyc[0] : -1, fst(1) + TMO + 1);
    check("tmo busy_profile", busy_bad, 0);

    // Completion on the last allowed CONV cycle wins over the timeout.
    do_reset(2); clear_logs();
    lat_r = TMO; ch_mask = 3'b001; period = PER_W'(1049); en = 1'b1;
    wait_starts(1, 1200);
    run_until(fst(0) + TMO + 2, 1200);
    check("edge timeout_err", timeout_err, 1'b0);
    check("edge ch_vld", ch_vld, 3'b001);
    check("edge ch_data0", ch_data[0 +: DATA_W], 12'h100);
    check("edge nxt count", nxt_cyc.size(), 1);
    check("edge nxt cycle", (nxt_cyc.size() > 0) ? nxt_cyc[0] : -1, fst(0) + TMO + 1);
    check("edge busy_profile", busy_bad, 0);

    // One cycle too late: timeout, and the stray done pulse in IDLE is ignored.
    do_reset(2); clear_logs();
    lat_r = TMO + 1; ch_mask = 3'b010; period = PER_W'(1049); en = 1'b1;
    wait_starts(1, 1200);
    run_until(fst(0) + TMO + 4, 1200);
    check("late rise", err_cyc - fst(0), TMO + 1);
    check("late ch_vld", ch_vld, '0);
    check("late ch_data", ch_data, '0);
    check("late busy", busy, 1'b0);

    // Reset in the middle of a conversion.
    do_reset(2); clear_logs();
    lat_r = 20; ch_mask = 3'b110; period = PER_W'(30); en = 1'b1;
    wait_starts(1, 100);
    s0 = fst(0);
    check("midrst first chnnl", fch(0), 1);
    repeat (5) step();
    check("midrst busy before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst strt_cnv", strt_cnv, 1'b0);
    check("midrst chnnl", chnnl, '0);
    check("midrst nxt", nxt, 1'b0);
    check("midrst timeout_err", timeout_err, 1'b0);
    run_until(s0 + 25, 100);
    check("midrst late cmplt ch_vld", ch_vld, '0);
    check("midrst late cmplt ch_data", ch_data, '0);
    check("midrst late cmplt nxt", nxt_cyc.size(), 0);
    wait_starts(2, 100);
    check("midrst restart chnnl", fch(1), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/a2d_seq.md
Name: a2d_seq

Overview:
- Parametrised A2D conversion sequencer for the segway digital core.
- Replaces the free-running 19-bit counter whose all-ones decode pulsed nxt.
- Paces conversions from a runtime-programmable period and steps round-robin through a maskable set of NUM_CH channels (default: lft_ld, rght_ld, batt).
- Runs a start/complete handshake with the A2D interface, captures each result into a per-channel register, pulses nxt at the end of each sweep, and flags stalled conversions.

Parameters:
NUM_CH, 3, number of A2D channels sequenced (1..8)
DATA_W, 12, A2D result width
PER_W, 19, width of the period counter and period input
TMO, 1024, cycles allowed in CONV before timeout (>=2)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  sequencing enable
ch_mask  in  NUM_CH  bit i=1 includes channel i in the sweep
period  in  PER_W  tick interval minus 1 (tick every period+1 cycles)
strt_cnv  out  1  one-cycle start pulse to A2D
chnnl  out  CH_W  channel under conversion; held from START through CONV
cnv_cmplt  in  1  A2D done pulse; res valid in same cycle
res  in  DATA_W  A2D result
ch_data  out  NUM_CH*DATA_W  packed latest results, channel i at [i*DATA_W +: DATA_W]
ch_vld  out  NUM_CH  sticky; bit i set on first capture for channel i
nxt  out  1  one-cycle pulse when a sweep completes
busy  out  1  high when state != IDLE
timeout_err  out  1  sticky conversion-timeout flag

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything, including mid-conversion. All outputs go to 0. Period counter and timeout counter clear. State goes to IDLE. Round-robin "last" pointer goes to NUM_CH-1, so the first pick is the lowest enabled channel.
- Period counter:
  - Increments while en=1.
  - When counter==period, tick=1 that cycle and the counter returns to 0.
  - period=0 produces a tick every cycle.
  - en=0 holds the counter at 0.
- FSM states IDLE, START, CONV:
  - IDLE: if tick=1 and ch_mask!=0, select the next channel and go to START. Next channel = smallest enabled index > last; if none, smallest enabled index. ch_mask is sampled in this cycle. Otherwise stay in IDLE.
  - START: strt_cnv=1 for exactly this cycle. chnnl holds the selected channel. Timeout counter clears. Go to CONV.
  - CONV on cnv_cmplt=1: write res into the ch_data slot for chnnl and set ch_vld[chnnl]. last<=chnnl. Go to IDLE.
  - CONV timeout: if the timeout counter reaches TMO-1 with no cnv_cmplt, set timeout_err. Do not capture. last<=chnnl. Go to IDLE. If cnv_cmplt arrives on that same cycle, the capture wins and no error is flagged.
- nxt:
  - Pulses in the cycle after leaving CONV, by completion or timeout.
  - Condition: chnnl equals the highest set index of ch_mask as sampled in the leaving cycle.
  - Single-channel mask: nxt pulses after every conversion.
- Latency: tick in IDLE at cycle T gives busy=1 and strt_cnv=1 at T+1. cnv_cmplt at cycle C gives updated ch_data, nxt and busy=0 at C+1.
- Ticks arriving while busy are dropped, not queued. The period counter keeps running.
- cnv_cmplt outside CONV is ignored.
- ch_mask changes during CONV do not abort the conversion; the result for the current chnnl is still captured.
- en=0 mid-conversion: the current conversion completes or times out normally. The FSM then stays in IDLE because no ticks arrive.
- chnnl is held at its last value while in IDLE.
- ch_data and ch_vld retain values until overwritten or reset. timeout_err clears only on rst.

Test Plan:
1. Reset/idle: assert rst 2 cycles, then en=0 for 50 cycles -> all outputs 0, no strt_cnv.
2. Round robin and nxt:
   - Stimulus: NUM_CH=3, mask=3'b111, period=9, A2D model completes 4 cycles after strt_cnv with res=0x100+chnnl.
   - Required: strt_cnv every 10 cycles with chnnl 0,1,2,0,…; the slot for channel 2 = 0x102; ch_vld=3'b111; nxt pulses once per 3 conversions, the cycle after the channel-2 capture.
3. Masking: mask=3'b101, period=4 -> chnnl sequence 0,2,0,2; channel 1 slot stays 0 and ch_vld[1]=0. Mask=0 -> no strt_cnv.
4. Timeout:
   - Stimulus: A2D never completes, TMO=1024.
   - Required: timeout_err rises exactly 1024 cycles after CONV entry and stays high; no capture; next tick starts the next channel.
   - Completion on the final cycle -> capture and no error.
5. Dropped ticks: period=0, A2D latency 6 -> strt_cnv spacing 8 cycles (START + 6-cycle CONV + 1 IDLE); no queued back-to-back starts.
6. Reset mid-CONV: rst during CONV then deasserted -> everything at reset values; the first start after reset is the lowest enabled channel; a late cnv_cmplt is ignored.
